// File: rtl/wb_stage.sv
// wb_stage -- final pipeline stage, drives the register-bank write port.
//
// Retiring instructions arrive from the memory stage over valid_i/ready_o.
// An ALU result is committed one cycle after it is accepted. A load waits in
// WAIT_MEM for mem_rvalid_i, then its byte, half or word is extracted and
// extended and committed one cycle later. Misaligned loads, illegal funct3
// values and loads whose data never arrives raise a one-cycle load_fault_o.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   valid_i / ready_o   retire handshake; ready_o is high only in IDLE
//   rd_addr_i           destination register
//   alu_result_i        result for non-load instructions
//   write_en_i          instruction writes rd
//   load_ctrl_i         instruction is a load
//   load_type_ctrl_i    funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   byte_offset_i       load address bits [1:0]
//   mem_rvalid_i        load data valid (sampled only in WAIT_MEM)
//   mem_rdata_i         raw aligned word from data memory
//   reg_waddr_o         register-bank write address (holds while wen=0)
//   reg_wdata_o         register-bank write data (holds while wen=0)
//   reg_wen_o           register-bank write enable, one-cycle pulse
//   stall_o             upstream stall while a load is outstanding
//   load_fault_o        one-cycle pulse for a faulted load
module wb_stage #(
   parameter int unsigned WORD_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned LOAD_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [WORD_WIDTH-1:0] alu_result_i,
   input  logic                  write_en_i,
   input  logic                  load_ctrl_i,
   input  logic [2:0]            load_type_ctrl_i,
   input  logic [1:0]            byte_offset_i,
   input  logic                  mem_rvalid_i,
   input  logic [WORD_WIDTH-1:0] mem_rdata_i,
   output logic [ADDR_WIDTH-1:0] reg_waddr_o,
   output logic [WORD_WIDTH-1:0] reg_wdata_o,
   output logic                  reg_wen_o,
   output logic                  stall_o,
   output logic                  load_fault_o
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT_MEM = 1'b1;

   localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

   logic [0:0]            r_state;
   logic [7:0]            r_count;
   logic [ADDR_WIDTH-1:0] r_rd;
   logic [2:0]            r_type;
   logic [1:0]            r_off;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_waddr;
   logic [WORD_WIDTH-1:0] r_wdata;
   logic                  r_wen;
   logic                  r_fault;

   logic                  w_accept;
   logic                  w_legal;
   logic                  w_misaligned;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [WORD_WIDTH-1:0] w_load_data;

   assign ready_o      = (r_state == S_IDLE);
   assign stall_o      = (r_state == S_WAIT_MEM);
   assign reg_waddr_o  = r_waddr;
   assign reg_wdata_o  = r_wdata;
   assign reg_wen_o    = r_wen;
   assign load_fault_o = r_fault;

   assign w_accept = valid_i && (r_state == S_IDLE);

   always_comb begin
      w_legal = 1'b0;
      case (load_type_ctrl_i)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
         default:                                w_legal = 1'b0;
      endcase
   end

   // Halfword loads (LH/LHU share funct3[1:0]=01) need an even offset; LW needs 0.
   assign w_misaligned = ((load_type_ctrl_i[1:0] == 2'b01) && byte_offset_i[0]) ||
                         ((load_type_ctrl_i == 3'b010) && (byte_offset_i != 2'b00));

   always_comb begin
      w_byte = '0;
      case (r_off)
         2'd0:    w_byte = mem_rdata_i[7:0];
         2'd1:    w_byte = mem_rdata_i[15:8];
         2'd2:    w_byte = mem_rdata_i[23:16];
         default: w_byte = mem_rdata_i[31:24];
      endcase
   end

   assign w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

   always_comb begin
      w_load_data = mem_rdata_i;
      case (r_type)
         3'b000:  w_load_data = {{(WORD_WIDTH-8){w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{(WORD_WIDTH-16){w_half[15]}}, w_half};
         3'b100:  w_load_data = {{(WORD_WIDTH-8){1'b0}}, w_byte};
         3'b101:  w_load_data = {{(WORD_WIDTH-16){1'b0}}, w_half};
         default: w_load_data = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_rd    <= '0;
         r_type  <= '0;
         r_off   <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_wen   <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_wen   <= 1'b0;
         r_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (!load_ctrl_i) begin
                     // Address/data only move on a real write so they hold otherwise.
                     if (write_en_i && (rd_addr_i != '0)) begin
                        r_wen   <= 1'b1;
                        r_waddr <= rd_addr_i;
                        r_wdata <= alu_result_i;
                     end
                  end else if (!w_legal || w_misaligned) begin
                     r_fault <= 1'b1;
                  end else begin
                     r_rd    <= rd_addr_i;
                     r_type  <= load_type_ctrl_i;
                     r_off   <= byte_offset_i;
                     r_we    <= write_en_i;
                     r_count <= '0;
                     r_state <= S_WAIT_MEM;
                  end
               end
            end
            S_WAIT_MEM: begin
               if (mem_rvalid_i) begin
                  if (r_we && (r_rd != '0)) begin
                     r_wen   <= 1'b1;
                     r_waddr <= r_rd;
                     r_wdata <= w_load_data;
                  end
                  r_state <= S_IDLE;
               end else if (r_count == TIMEOUT_LAST) begin
                  r_fault <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_count <= r_count + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
